// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions, FSM encoding and opcode classification helpers.
package alu_pkg;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_ADD = 6'b001001;
  localparam logic [5:0] OP_SUB = 6'b001010;
  localparam logic [5:0] OP_ADC = 6'b001011;
  localparam logic [5:0] OP_SBB = 6'b001100;
  localparam logic [5:0] OP_AND = 6'b001101;
  localparam logic [5:0] OP_OR  = 6'b001110;
  localparam logic [5:0] OP_MOV = 6'b001111;
  localparam logic [5:0] OP_MUL = 6'b010000;
  localparam logic [5:0] OP_DIV = 6'b010001;
  localparam logic [5:0] OP_MOD = 6'b010010;
  localparam logic [5:0] OP_XOR = 6'b010011;
  localparam logic [5:0] OP_SHL = 6'b010100;
  localparam logic [5:0] OP_SHR = 6'b010101;
  localparam logic [5:0] OP_NOT = 6'b010110;
  localparam logic [5:0] OP_SAR = 6'b010111;
  localparam logic [5:0] OP_CMP = 6'b011000;
  localparam logic [5:0] OP_INC = 6'b011001;
  localparam logic [5:0] OP_DEC = 6'b011010;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 10;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 7;
  localparam int RA_MSB  = 6;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 1;
  localparam int IMM_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

  // Single-operand ops take the immediate on port a instead of port b.
  function automatic logic is_imm_unary(input logic [5:0] op);
    return (op == OP_MOV) || (op == OP_NOT) || (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register file: one write port, two operand read ports and a
// debug read port, all reads combinational. Entry 0 always reads zero.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [DW-1:0]            o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [DW-1:0]            o_rdata_b,
  input  logic [$clog2(NREGS)-1:0] i_dbg_addr,
  output logic [DW-1:0]            o_dbg_data
);

  logic [DW-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state sequencer feeding an external combinational ALU: accept, read
// operands and drive the ALU, capture the result, then retire or flag an error.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [15:0]              instr,
  input  logic [DW-1:0]            imm,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [5:0]               alu_opcode,
  input  logic [DW-1:0]            alu_result,
  input  logic                     alu_zf,
  input  logic                     alu_cf,
  input  logic                     alu_nf,
  input  logic                     alu_of,
  output logic                     done,
  output logic [DW-1:0]            done_result,
  output logic [3:0]               flags_q,
  output logic                     err,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_instr;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [5:0]    r_alu_op;
  logic [DW-1:0] r_res_hold;
  logic [3:0]    r_flags_hold;
  logic          r_err_hold;
  logic          r_done;
  logic          r_err;
  logic [DW-1:0] r_done_result;
  logic [3:0]    r_flags_q;

  logic [5:0]    w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic          w_use_imm;
  logic [DW-1:0] w_rdata_a;
  logic [DW-1:0] w_rdata_b;
  logic [DW-1:0] w_issue_a;
  logic [DW-1:0] w_issue_b;
  logic [5:0]    w_issue_op;
  logic          w_div_by_zero;
  logic          w_we;

  assign w_op      = r_instr[OP_MSB:OP_LSB];
  assign w_rd      = r_instr[RD_MSB:RD_LSB];
  assign w_ra      = r_instr[RA_MSB:RA_LSB];
  assign w_rb      = r_instr[RB_MSB:RB_LSB];
  assign w_use_imm = r_instr[IMM_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue_a  = w_rdata_a;
    w_issue_b  = w_rdata_b;
    w_issue_op = is_legal_op(w_op) ? w_op : OP_NOP;
    if (w_use_imm) begin
      if (is_imm_unary(w_op)) begin
        w_issue_a = r_imm;
        w_issue_b = '0;
      end else begin
        w_issue_b = r_imm;
      end
    end
  end

  // Divisor check looks at the operand actually driven, covering imm and register forms alike.
  assign w_div_by_zero = ((w_op == OP_DIV) || (w_op == OP_MOD)) && (r_alu_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr       <= '0;
      r_imm         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= OP_NOP;
      r_res_hold    <= '0;
      r_flags_hold  <= '0;
      r_err_hold    <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_done_result <= '0;
      r_flags_q     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_imm   <= imm;
          end
        end
        S_ISSUE: begin
          r_alu_a  <= w_issue_a;
          r_alu_b  <= w_issue_b;
          r_alu_op <= w_issue_op;
        end
        S_EXEC: begin
          r_res_hold   <= alu_result;
          r_flags_hold <= {alu_zf, alu_cf, alu_nf, alu_of};
          r_err_hold   <= !is_legal_op(w_op) || w_div_by_zero;
        end
        S_WB: begin
          r_done <= 1'b1;
          r_err  <= r_err_hold;
          if (r_err_hold) begin
            r_done_result <= '1;
          end else begin
            r_done_result <= r_res_hold;
            r_flags_q     <= r_flags_hold;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_we = (r_state == S_WB) && !r_err_hold;

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (r_res_hold),
    .i_raddr_a  (w_ra),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (w_rb),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  assign instr_ready = (r_state == S_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_op;
  assign done        = r_done;
  assign err         = r_err;
  assign done_result = r_done_result;
  assign flags_q     = r_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the far side, and a
// register-file/flags reference model driven from the instruction rules.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_zf, alu_cf, alu_nf, alu_of;
  logic        done;
  logic [15:0] done_result;
  logic [3:0]  flags_q;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_r [8];
  logic [3:0]  m_flags;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREGS(8), .DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .imm         (imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_zf      (alu_zf),
    .alu_cf      (alu_cf),
    .alu_nf      (alu_nf),
    .alu_of      (alu_of),
    .done        (done),
    .done_result (done_result),
    .flags_q     (flags_q),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Returns {ZF,CF,NF,OF,result}.
  function automatic logic [19:0] alu_fn(input logic [5:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] wide;
    logic [15:0] res;
    logic        cf, of;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      OP_ADD: begin wide = {1'b0, a} + {1'b0, b}; res = wide[15:0]; cf = wide[16];
                    of = (a[15] == b[15]) && (res[15] != a[15]); end
      OP_SUB: begin res = a - b; cf = (a < b); of = (a[15] != b[15]) && (res[15] != a[15]); end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_MOV: res = a;
      OP_NOT: res = ~a;
      OP_INC: res = a + 16'd1;
      OP_DEC: res = a - 16'd1;
      OP_MUL: res = a * b;
      OP_DIV: res = (b == 0) ? 16'hFFFF : a / b;
      OP_MOD: res = (b == 0) ? a : a % b;
      OP_SHL: res = a << b[3:0];
      OP_SHR: res = a >> b[3:0];
      OP_NOP: res = 16'h0000;
      default: res = a ^ (b + {10'd0, op});
    endcase
    return {(res == 16'h0000), cf, res[15], of, res};
  endfunction

  logic [19:0] w_alu_out;
  assign w_alu_out  = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_result = w_alu_out[15:0];
  assign alu_zf     = w_alu_out[19];
  assign alu_cf     = w_alu_out[18];
  assign alu_nf     = w_alu_out[17];
  assign alu_of     = w_alu_out[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_flags = 4'h0;
  endtask

  // One full instruction: accept, check ALU drive in EXEC, check retire.
  task automatic run_instr(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic ui, input logic [15:0] imm_v);
    logic        legal, unary, e_err;
    logic [15:0] e_a, e_b, e_res;
    logic [5:0]  e_op;
    logic [19:0] r;
    int          n;
    legal = (op >= 6'd9) && (op <= 6'd26);
    unary = (op == 6'd15) || (op == 6'd22) || (op == 6'd25) || (op == 6'd26);
    e_a   = (ui && unary) ? imm_v : m_r[ra];
    e_b   = ui ? (unary ? 16'h0000 : imm_v) : m_r[rb];
    e_op  = legal ? op : 6'd0;
    e_err = !legal || (((op == 6'd17) || (op == 6'd18)) && (e_b == 16'h0000));
    if (e_err) begin
      e_res = 16'hFFFF;
    end else begin
      r     = alu_fn(op, e_a, e_b);
      e_res = r[15:0];
      m_flags = r[19:16];
      if (rd != 3'd0) m_r[rd] = e_res;
    end

    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = {op, rd, ra, rb, ui};
    imm         = imm_v;
    dbg_addr    = rd;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("ready_issue", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    check("alu_a", {16'd0, alu_a}, {16'd0, e_a});
    check("alu_b", {16'd0, alu_b}, {16'd0, e_b});
    check("alu_op", {26'd0, alu_opcode}, {26'd0, e_op});
    check("done_exec", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("done_wb", {31'd0, done | instr_ready}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("err", {31'd0, err}, {31'd0, e_err});
    check("done_result", {16'd0, done_result}, {16'd0, e_res});
    check("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
    check("dbg_rd", {16'd0, dbg_data}, {16'd0, m_r[rd]});
    $display("txn op=%b rd=%0d ra=%0d rb=%0d imm_sel=%0b imm=%h -> res=%h err=%0b flags=%h",
             op, rd, ra, rb, ui, imm_v, done_result, err, flags_q);
  endtask

  initial begin
    logic        rdy_b;
    logic [19:0] r;
    logic [5:0]  rop;
    logic [15:0] rimm;
    int          done_seen;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    imm         = 16'h0000;
    dbg_addr    = 3'd0;
    clear_model();
    #2;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_op", {26'd0, alu_opcode}, 32'd0);
    check("rst_done", {31'd0, done | err}, 32'd0);
    check("rst_result", {16'd0, done_result}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_instr(OP_MOV, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0011);
    run_instr(OP_MOV, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0002);
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
    run_instr(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b0, 16'h0000);
    run_instr(OP_SUB, 3'd5, 3'd1, 3'd1, 1'b0, 16'h0000);
    run_instr(OP_DIV, 3'd6, 3'd1, 3'd0, 1'b0, 16'h0000);
    run_instr(6'b111111, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000);
    run_instr(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000);
    run_instr(OP_ADD, 3'd7, 3'd1, 3'd0, 1'b1, 16'h8000);

    // instr_valid held high across three ADD r3 = r3 + r1.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = {OP_ADD, 3'd3, 3'd3, 3'd1, 1'b0};
    dbg_addr    = 3'd3;
    for (int cyc = 0; cyc < 12; cyc++) begin
      rdy_b = instr_ready;
      @(posedge clk); #1;
      if (cyc == 8) instr_valid = 1'b0;
      check("held_ready", {31'd0, rdy_b}, {31'd0, (cyc % 4 == 0)});
      if (cyc % 4 == 3) begin
        r = alu_fn(OP_ADD, m_r[3], m_r[1]);
        m_r[3]  = r[15:0];
        m_flags = r[19:16];
        check("held_done", {31'd0, done}, 32'd1);
        check("held_result", {16'd0, done_result}, {16'd0, m_r[3]});
        $display("txn held ADD r3 -> res=%h flags=%h", done_result, flags_q);
      end else begin
        check("held_nodone", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
    end

    // Reset while in EXEC.
    instr_valid = 1'b1;
    instr       = {OP_ADD, 3'd7, 3'd3, 3'd1, 1'b0};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    clear_model();
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_op", {26'd0, alu_opcode}, 32'd0);
    check("mid_rst_a", {16'd0, alu_a}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_flags", {28'd0, flags_q}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      check("mid_rst_reg", {16'd0, dbg_data}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("mid_rst_nodone", done_seen, 32'd0);
    $display("txn reset during EXEC, state cleared");

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0:       rop = 6'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom_range(27, 63));
        1:       rop = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_MOD;
        default: rop = 6'($urandom_range(9, 26));
      endcase
      rimm = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_instr(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rimm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle sequencer that drives the combinational 16-bit ALU from the operand/opcode side.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives a, b and opcode to the ALU, captures result and ZF/CF/NF/OF, writes the result back and reports completion.
- Sits between the instruction source (fetch or testbench) and the ALU.

Parameters:
- NREGS, 8, register-file depth; register index width is clog2(NREGS)=3.
- DW, 16, datapath width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr  in  16  [15:10] opcode, [9:7] rd, [6:4] ra, [3:1] rb, [0] use_imm.
- imm  in  DW  immediate, sampled together with instr.
- alu_a  out  DW  ALU operand a (registered).
- alu_b  out  DW  ALU operand b (registered).
- alu_opcode  out  6  ALU opcode (registered).
- alu_result  in  DW  ALU result.
- alu_zf, alu_cf, alu_nf, alu_of  in  1 each  ALU flags.
- done  out  1  one-cycle pulse when the instruction retires.
- done_result  out  DW  retired result, held until the next retire.
- flags_q  out  4  {ZF,CF,NF,OF} of the last successful retire.
- err  out  1  one-cycle pulse coincident with done on an error retire.
- dbg_addr  in  3  debug read index.
- dbg_data  out  DW  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async assert, sync release): state IDLE, all registers 0, alu_a/alu_b 0, alu_opcode 6'b000000, done/err 0, done_result 0, flags_q 0, instr_ready 1.
- Legal opcodes: 001001 through 011010. Anything else is illegal.
- FSM, one state per cycle:
  - IDLE -> ISSUE on instr_valid && instr_ready. Latch instr and imm.
  - ISSUE -> EXEC. Register the ALU drive:
    - alu_opcode = op.
    - Normal case: alu_a = R[ra], alu_b = R[rb].
    - use_imm=1 and op in {MOV 001111, NOT 010110, INC 011001, DEC 011010}: alu_a = imm, alu_b = 0.
    - use_imm=1, any other op: alu_b = imm.
    - Illegal op: alu_opcode = 000000.
  - EXEC -> WB. Sample alu_result and the flags into holding registers; the ALU has settled for a full cycle.
  - WB -> IDLE. Write R[rd] = result, update flags_q, done_result = result, pulse done.
- Latency: done asserts exactly 3 cycles after the accept edge. Throughput is 1 instruction per 4 cycles. instr_ready is 0 in ISSUE, EXEC and WB.
- R0 is hardwired to 0: writes to rd=0 are discarded, but done, done_result and flags_q still update.
- Error retire, in WB, pulses done and err with no regfile write, flags_q unchanged and done_result = 16'hFFFF. Causes:
  - illegal opcode;
  - DIV (010001) or MOD (010010) with alu_b == 0.
- Operand read happens in ISSUE, so the previous instruction's write (completed in its WB) is always visible. No hazards.
- instr_valid held high during a busy period is ignored; the next accept happens in the cycle after WB, when the FSM is back in IDLE.
- Reset mid-operation: instantly IDLE with all state cleared. No done pulse; the in-flight write is lost.
- dbg_data reflects a write on the cycle after WB.
- Arithmetic width: results are truncated to DW by the ALU. The controller does not widen or recompute flags.

Decomposition:
- Shared package alu_pkg:
  - localparams for every ALU opcode (OP_ADD=6'b001001 … OP_DEC=6'b011010, OP_NOP=6'b000000);
  - instruction field bit positions;
  - FSM state encoding (IDLE, ISSUE, EXEC, WB);
  - function is_legal_op.
- One sub-module, alu_regfile: NREGS x DW array with one write port, two combinational read ports plus the debug read port, R0 forced to 0, async active-low clear.

Test Plan:
- MOV r1 with imm 0x0011 (use_imm=1), then MOV r2 with imm 0x0002 -> done 3 cycles after each accept; dbg r1=0x0011, r2=0x0002.
- ADD r3=r1+r2 -> alu_a=0x0011, alu_b=0x0002, opcode 001001 in EXEC; done_result=0x0013, ZF=0.
- SUB r4=r2-r1 -> done_result=0xFFF1, r4=0xFFF1. Then SUB r5=r1-r1 -> 0x0000, flags_q[3] (ZF)=1.
- DIV r6=r1/r0 -> done and err pulse together, done_result=0xFFFF, r6 stays 0, flags_q unchanged. Repeat with illegal opcode 6'b111111 -> same error retire.
- instr_valid held high across 3 back-to-back ADDs -> instr_ready low in ISSUE/EXEC/WB, accepts spaced 4 cycles apart, 3 done pulses. ADD to rd=0 -> r0 reads 0.
- Deassert rst_n during EXEC -> immediately IDLE, instr_ready=1, alu_opcode=000000, no done, all registers read 0.
